maxpool2: RTL and testbench

Downstream stage of the binary convolution unit. Consumes the convolution's signed 16-bit output stream (`dout`/`ovalid`) and performs 2x2, stride-2 max pooling over the valid conv feature map. The map is 24x24 for layer 1 and 8x8 for layer 2. The block emits the pooled map (12x12 or 4x4) in raster order to the next stage (activation/binarization) and flags frame completion.

---
 rtl/maxpool2_pkg.sv | 7 +
 rtl/pool_line_buf.sv | 28 ++
 rtl/maxpool2.sv | 104 ++++++++++
 tb/tb_maxpool2.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool2_pkg.sv
// Shared constants for the 2x2 max-pool stage that follows the binary convolution unit.
package maxpool2_pkg;
  localparam int DW   = 16;
  localparam int W_L1 = 24;
  localparam int W_L2 = 8;
  localparam int POOL = 2;
endpackage

// File: rtl/pool_line_buf.sv
// Holds one row of horizontal pair maxima until the odd row arrives to finish each window.
module pool_line_buf #(
  parameter int DW    = 16,
  parameter int DEPTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maxpool2.sv
// 2x2 stride-2 max pooling over the conv output stream; emits the pooled map in raster order.
module maxpool2
  import maxpool2_pkg::*;
#(
  parameter int DW   = maxpool2_pkg::DW,
  parameter int MAXW = W_L1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 state,
  input  logic signed [DW-1:0] din,
  input  logic                 ivalid,
  output logic signed [DW-1:0] dout,
  output logic                 ovalid,
  output logic                 done
);

  localparam int CW    = $clog2(MAXW);
  localparam int DEPTH = MAXW / POOL;
  localparam int AW    = $clog2(DEPTH);

  logic        [CW-1:0] r_col;
  logic        [CW-1:0] r_row;
  logic signed [DW-1:0] r_hold;
  logic signed [DW-1:0] r_dout;
  logic                 r_ovalid;
  logic                 r_done;

  logic        [CW-1:0] w_last;
  logic                 w_accept;
  logic                 w_colLast;
  logic                 w_rowLast;
  logic        [AW-1:0] w_idx;
  logic                 w_we;
  logic signed [DW-1:0] w_hmax;
  logic signed [DW-1:0] w_bufRd;
  logic signed [DW-1:0] w_vmax;

  assign w_last    = state ? CW'(W_L2 - 1) : CW'(W_L1 - 1);
  assign w_accept  = ivalid && start;
  assign w_colLast = (r_col == w_last);
  assign w_rowLast = (r_row == w_last);
  assign w_idx     = AW'(r_col >> 1);
  assign w_we      = w_accept && r_col[0] && !r_row[0];

  // Both operands are signed, so these compares are two's complement.
  assign w_hmax = (din > r_hold) ? din : r_hold;
  assign w_vmax = (w_bufRd > w_hmax) ? w_bufRd : w_hmax;

  pool_line_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (w_hmax),
    .i_raddr (w_idx),
    .o_rdata (w_bufRd)
  );

  // Dropping start clears position and flags; hold/dout keep stale data that is always rewritten before use.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col    <= '0;
      r_row    <= '0;
      r_hold   <= '0;
      r_dout   <= '0;
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
    end else if (!start) begin
      r_col    <= '0;
      r_row    <= '0;
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
      if (w_accept) begin
        if (!r_col[0]) begin
          r_hold <= din;
        end else if (r_row[0]) begin
          r_dout   <= w_vmax;
          r_ovalid <= 1'b1;
          r_done   <= w_colLast && w_rowLast;
        end
        if (w_colLast) begin
          r_col <= '0;
          r_row <= w_rowLast ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign dout   = r_dout;
  assign ovalid = r_ovalid;
  assign done   = r_done;

endmodule

// File: tb/tb_maxpool2.sv
// Scoreboard bench for maxpool2: stimulus pushes hand-derived window maxima, a negedge monitor pops and compares.
module tb_maxpool2;

  typedef struct packed {
    logic signed [15:0] data;
    logic               last;
  } expT;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic               state;
  logic signed [15:0] din;
  logic               ivalid;
  logic signed [15:0] dout;
  logic               ovalid;
  logic               done;

  expT expQ[$];
  int  checks = 0;
  int  failures = 0;
  int  doneExpected = 0;
  int  doneSeen = 0;

  maxpool2 dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .state  (state),
    .din    (din),
    .ivalid (ivalid),
    .dout   (dout),
    .ovalid (ovalid),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Mode 0: ramp, mode 1: negated 8-wide ramp, mode 2: rotating signed extremes per window.
  function automatic logic signed [15:0] pixel(input int mode, input int w, input int r, input int c);
    int pos;
    int rot;
    logic signed [15:0] v;
    v = '0;
    case (mode)
      0: v = 16'(r * w + c);
      1: v = 16'(-(r * 8 + c));
      default: begin
        pos = (r % 2) * 2 + (c % 2);
        rot = ((r / 2) * (w / 2) + c / 2) % 4;
        case ((pos + rot) % 4)
          0: v = -16'sd32768;
          1: v = 16'sd32767;
          2: v = -16'sd1;
          default: v = 16'sd0;
        endcase
      end
    endcase
    return v;
  endfunction

  function automatic logic signed [15:0] windowMax(input int mode, input int w, input int r, input int c);
    logic signed [15:0] v;
    case (mode)
      0: v = 16'(r * w + c);
      1: v = 16'(-((r - 1) * 8 + (c - 1)));
      default: v = 16'sd32767;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input int st, input int mode, input bit randomGaps,
                               input int limit, input bit dropOnLast);
    int  w;
    int  sent;
    bit  killed;
    expT e;
    w = st ? 8 : 24;
    sent = 0;
    state = st[0];
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (sent == limit) return;
        killed = dropOnLast && (r == w - 1) && (c == w - 1);
        if ((r % 2 == 1) && (c % 2 == 1) && !killed) begin
          e.data = windowMax(mode, w, r, c);
          e.last = (r == w - 1) && (c == w - 1);
          expQ.push_back(e);
          if (e.last) doneExpected++;
        end
        din = pixel(mode, w, r, c);
        ivalid = 1'b1;
        if (killed) start = 1'b0;
        @(posedge clk); #1;
        ivalid = 1'b0;
        sent++;
        if (randomGaps && $urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
      repeat (4) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic restartFrame();
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
  endtask

  // Monitor: every presented output must match the oldest pending expectation.
  always @(negedge clk) begin
    expT e;
    if (rstn) begin
      if (ovalid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got dout=%0d, expected no output", dout);
        end else begin
          e = expQ.pop_front();
          checkOutput("dout", int'(dout), int'(e.data));
          checkOutput("done_with_output", int'(done), int'(e.last));
          if (done) doneSeen++;
        end
      end else if (done) begin
        checks++;
        failures++;
        $display("[TB] FAIL stray_done: got done=1 without ovalid, expected 0");
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got no completion, expected finish before 1ms");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstn = 1'b1;
    start = 1'b0;
    state = 1'b0;
    din = '0;
    ivalid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_ovalid", int'(ovalid), 0);
    checkOutput("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] 24x24 ramp, contiguous rows");
    start = 1'b1;
    applyStimulus(0, 0, 1'b0, 576, 1'b0);

    $display("[TB] 8x8 negative ramp");
    restartFrame();
    applyStimulus(1, 1, 1'b0, 64, 1'b0);

    $display("[TB] 8x8 signed extremes");
    restartFrame();
    applyStimulus(1, 2, 1'b0, 64, 1'b0);

    $display("[TB] 24x24 ramp with random bubbles");
    restartFrame();
    applyStimulus(0, 0, 1'b1, 576, 1'b0);

    $display("[TB] start dropped after 30 samples, then fresh 8x8 frame");
    restartFrame();
    applyStimulus(0, 0, 1'b0, 30, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 16'sd999;
      ivalid = 1'b1;
      @(posedge clk); #1;
    end
    ivalid = 1'b0;
    start = 1'b1;
    applyStimulus(1, 1, 1'b0, 64, 1'b0);

    $display("[TB] start falls together with final sample");
    restartFrame();
    applyStimulus(1, 1, 1'b0, 64, 1'b1);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    applyStimulus(1, 2, 1'b0, 64, 1'b0);

    $display("[TB] reset pulsed after 50 samples");
    restartFrame();
    applyStimulus(0, 0, 1'b0, 50, 1'b0);
    rstn = 1'b0;
    #1;
    checkOutput("midreset_dout", int'(dout), 0);
    checkOutput("midreset_ovalid", int'(ovalid), 0);
    checkOutput("midreset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    applyStimulus(0, 0, 1'b0, 576, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("pending_outputs", expQ.size(), 0);
    checkOutput("done_count", doneSeen, doneExpected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
